// File: rtl/booth_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_multiplier_pkg
// Description : Shared definitions for the execute-stage Booth multiplier:
//               datapath width, FSM state encodings and Booth operation codes.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_multiplier_pkg;

    // Datapath width; matches the shared hybridAdder.
    localparam int c_XLEN = 32;

    // Multiplier FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Constant views of the state encoding for the registered state.
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Operation selected by the Booth pair {Q[0], q_m1}.
    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    // Decode a Booth pair {Q[0], q_m1} into the operation to perform.
    function automatic booth_op_e booth_decode(input logic [1:0] pair);
        booth_op_e op;
        case (pair)
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hybridAdder.sv
`default_nettype none
// ============================================================================
// Module      : hybridAdder
// Description : 32-bit two-operand adder with carry-in, shared between the
//               ALU and the Booth multiplier.
//   a     in  32  first operand
//   b     in  32  second operand
//   c_in  in  1   carry in
//   S     out 32  sum
//   c_out out 1   carry out
// Revision    : 1.0 - initial release
// ============================================================================
module hybridAdder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] S,
    output logic        c_out
);

    logic [32:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
    assign S      = w_full[31:0];
    assign c_out  = w_full[32];

endmodule
`default_nettype wire

// File: rtl/booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : booth_multiplier
// Description : Multi-cycle signed 32x32 radix-2 Booth multiplier. One Booth
//               step per cycle through the shared hybridAdder; 64-bit product
//               registered and held until the next completion.
//   clk          in  1   rising-edge clock
//   rst          in  1   synchronous active-high reset
//   start        in  1   request, sampled only when not busy
//   multiplicand in  32  signed operand M
//   multiplier   in  32  signed operand Q
//   busy         out 1   high while iterating
//   done         out 1   one-cycle pulse when product is updated
//   product      out 64  signed M x Q
// Revision    : 1.0 - initial release
// ============================================================================
module booth_multiplier
    import booth_multiplier_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    logic [1:0]        r_state;
    logic [c_XLEN-1:0] r_a;
    logic [c_XLEN-1:0] r_q;
    logic              r_q_m1;
    logic [c_XLEN-1:0] r_m;
    logic [5:0]        r_cnt;
    logic [63:0]       r_product;

    booth_op_e         w_op;
    logic [c_XLEN-1:0] w_adder_b;
    logic              w_adder_cin;
    logic [c_XLEN-1:0] w_adder_s;
    logic              w_adder_cout_unused;
    logic [c_XLEN-1:0] w_sum;
    logic              w_ovf;
    logic              w_sign;
    logic              w_accept;

    // ------------------------------------------------------------------
    // Booth step datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_op        = booth_decode({r_q[0], r_q_m1});
        w_adder_b   = r_m;
        w_adder_cin = 1'b0;
        if (w_op == BOOTH_SUB) begin
            w_adder_b   = ~r_m;
            w_adder_cin = 1'b1;
        end
    end

    hybridAdder u_adder (
        .a     (r_a),
        .b     (w_adder_b),
        .c_in  (w_adder_cin),
        .S     (w_adder_s),
        .c_out (w_adder_cout_unused)
    );

    // The true sum is 33 bits wide; when the 32-bit add overflows, S[31]
    // is the wrong sign, so flipping it recovers bit 32 for the shift-in.
    // Without this, M = -2^31 produces a corrupted high word.
    always_comb begin
        w_sum  = r_a;
        w_ovf  = 1'b0;
        w_sign = r_a[c_XLEN-1];
        if (w_op != BOOTH_NOP) begin
            w_sum  = w_adder_s;
            w_ovf  = (r_a[c_XLEN-1] == w_adder_b[c_XLEN-1]) &&
                     (w_adder_s[c_XLEN-1] != r_a[c_XLEN-1]);
            w_sign = w_adder_s[c_XLEN-1] ^ w_ovf;
        end
    end

    assign w_accept = start && (r_state != c_ST_RUN);

    // ------------------------------------------------------------------
    // FSM, shift registers and product register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_q_m1    <= 1'b0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    // {A, Q, q_m1} <- {sign, sum, Q} (arithmetic right shift)
                    r_a    <= {w_sign, w_sum[c_XLEN-1:1]};
                    r_q    <= {w_sum[0], r_q[c_XLEN-1:1]};
                    r_q_m1 <= r_q[0];
                    r_cnt  <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_product <= {w_sign, w_sum, r_q[c_XLEN-1:1]};
                        r_state   <= c_ST_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    if (w_accept) begin
                        r_a     <= '0;
                        r_q     <= multiplier;
                        r_q_m1  <= 1'b0;
                        r_m     <= multiplicand;
                        r_cnt   <= '0;
                        r_state <= c_ST_RUN;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = (r_state == c_ST_RUN);
    assign done    = (r_state == c_ST_DONE);
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_multiplier
// Description : Scoreboard testbench for booth_multiplier. The driver pushes
//               hand-computed products and accept times; a monitor pops and
//               compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int          n_cmp;
    int          n_fail;
    int          cyc;

    logic [63:0] exp_q[$];
    int          time_q[$];

    booth_multiplier dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            check("done_busy_overlap", {63'd0, busy}, 64'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got product 0x%016h expected no done", product);
            end else begin
                check("product", product, exp_q.pop_front());
                check("latency", 64'(cyc - time_q.pop_front()), 64'd32);
            end
        end
    end

    // Issue one request; start is left high when keep is set.
    task automatic do_op(input logic [31:0] m, input logic [31:0] q,
                         input logic [63:0] e, input bit expect_done, input bit keep);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clk);
        #1;
        if (expect_done) begin
            exp_q.push_back(e);
            time_q.push_back(cyc);
        end
        if (!keep) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        @(negedge clk);
        while ((busy || done) && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (busy || done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=%0b done=%0b expected both 0", busy, done);
        end
    endtask

    initial begin
        int i;
        n_cmp        = 0;
        n_fail       = 0;
        cyc          = 0;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state held through idle cycles.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("reset_busy", {63'd0, busy}, 64'd0);
            check("reset_done", {63'd0, done}, 64'd0);
            check("reset_product", product, 64'd0);
        end

        // Basic and boundary products.
        do_op(32'd6, 32'd7, 64'd42, 1'b1, 1'b0);                         wait_idle();
        do_op(-32'sd49, -32'sd77, 64'd3773, 1'b1, 1'b0);                 wait_idle();
        do_op(32'd41, -32'sd27, 64'hFFFF_FFFF_FFFF_FBAD, 1'b1, 1'b0);    wait_idle();
        do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, 1'b0); wait_idle();
        do_op(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0); wait_idle();
        do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1, 1'b0); wait_idle();

        // Start during RUN is ignored.
        do_op(32'd5, 32'd5, 64'd25, 1'b1, 1'b0);
        repeat (9) @(negedge clk);
        start        = 1'b1;
        multiplicand = 32'd3;
        multiplier   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("held_product", product, 64'd25);

        // Start held high through DONE: back-to-back operations.
        do_op(32'd12, 32'd11, 64'd132, 1'b1, 1'b1);
        multiplicand = 32'd14;
        multiplier   = 32'd11;
        i = 0;
        @(negedge clk);
        while (!done && i < 100) begin
            @(negedge clk);
            i++;
        end
        @(posedge clk);
        #1;
        exp_q.push_back(64'd154);
        time_q.push_back(cyc);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset mid-operation aborts with no done pulse.
        do_op(32'h1234, 32'h5678, 64'd0, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_product_held", product, 64'd0);
        do_op(32'h1234, 32'h5678, 64'h0000_0000_0626_0060, 1'b1, 1'b0);
        wait_idle();

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL missing_done: got %0d outstanding expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
